// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   This unit executes the 4-bit ALU control code that the ALU control
//   decoder produces. It sits between the operand mux and the
//   writeback/branch logic.
//   AND, OR and illegal codes finish in one cycle. ADD and SUB run as two
//   half-width cycles: the low half first, then the high half, which uses
//   the registered carry from the low half.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operands and control are valid
//   in_ready   unit can accept an operation (IDLE and not in reset)
//   alu_ctrl   0000 AND, 0001 OR, 0010 ADD, 0110 SUB; all other codes are illegal
//   op_a       operand A
//   op_b       operand B
//   out_valid  result/zero/error are valid
//   out_ready  downstream accepts the result
//   result     operation result, modulo 2^WIDTH
//   zero       result == 0, computed over the full width
//   error      the accepted alu_ctrl was illegal
//
// Handshake: a transfer occurs on a rising edge where valid && ready.
//   valid never depends combinationally on ready. Once out_valid is
//   asserted, result/zero/error hold steady until that transfer.
//   in_ready is low in DONE, so a new operation can never be accepted in
//   the same cycle that a result is handed off.
//
// The FSM state (IDLE/HIGH/DONE) is held in the typed register 'state'.
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 64  // must be even
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             error
);

  localparam int HALF = WIDTH / 2;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [HALF-1:0] a_hi_q;
  logic [HALF-1:0] b_hi_q;   // B already inverted for SUB
  logic [HALF-1:0] lo_q;
  logic            carry_q;

  logic             accept;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [HALF:0]    lo_full;
  logic [HALF-1:0]  hi_sum;
  logic [WIDTH-1:0] full_sum;
  logic [WIDTH-1:0] logic_res;

  assign in_ready = (state == IDLE) && !reset;
  assign accept   = in_valid && in_ready;

  // SUB is computed as A + ~B + 1. The +1 enters as the carry-in of the
  // low half. The high half uses only the registered carry.
  assign is_sub  = (alu_ctrl == CTRL_SUB);
  assign b_eff   = is_sub ? ~op_b : op_b;
  assign lo_full = {1'b0, op_a[HALF-1:0]} + {1'b0, b_eff[HALF-1:0]}
                 + {{HALF{1'b0}}, is_sub};

  // The carry out of the high half is dropped: arithmetic is modulo 2^WIDTH.
  assign hi_sum   = a_hi_q + b_hi_q + {{(HALF-1){1'b0}}, carry_q};
  assign full_sum = {hi_sum, lo_q};

  assign logic_res = (alu_ctrl == CTRL_AND) ? (op_a & op_b) : (op_a | op_b);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      error     <= 1'b0;
      a_hi_q    <= '0;
      b_hi_q    <= '0;
      lo_q      <= '0;
      carry_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (alu_ctrl)
              CTRL_AND, CTRL_OR: begin
                result    <= logic_res;
                zero      <= (logic_res == '0);
                error     <= 1'b0;
                out_valid <= 1'b1;
                state     <= DONE;
              end
              CTRL_ADD, CTRL_SUB: begin
                lo_q    <= lo_full[HALF-1:0];
                carry_q <= lo_full[HALF];
                a_hi_q  <= op_a[WIDTH-1:HALF];
                b_hi_q  <= b_eff[WIDTH-1:HALF];
                state   <= HIGH;
              end
              default: begin
                result    <= '0;
                zero      <= 1'b1;
                error     <= 1'b1;
                out_valid <= 1'b1;
                state     <= DONE;
              end
            endcase
          end
        end
        HIGH: begin
          result    <= full_sum;
          zero      <= (full_sum == '0);
          error     <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
